pe_window_region_gen: RTL and testbench

Per-pixel window-region generator for the priority evaluation stage. Tracks the current scanline and pixel position against the WIN0H/WIN0V/WIN1H/WIN1V registers and produces the `win0`/`win1` inside-window flags consumed by the window masker. Flags are aligned one clock behind each pixel strobe. Per-line edge-tracking flags implement the GBA rectangle, including the wrap-around case (start coordinate greater than end).

---
 rtl/pe_window_region_gen.sv | 88 ++++++++
 tb/tb_pe_window_region_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_window_region_gen.sv
// Per-pixel WIN0/WIN1 inside-window flags, registered one clock behind pixel_valid.
// Optional macro WINDOW_SHADOW_EN latches the horizontal window registers at line_start.
module pe_window_region_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  vcount,
  input  logic        pixel_valid,
  input  logic [15:0] win0h,
  input  logic [15:0] win1h,
  input  logic [15:0] win0v,
  input  logic [15:0] win1v,
  input  logic [15:0] dispcnt,
  output logic        win0,
  output logic        win1,
  output logic        out_valid
);

  localparam logic [7:0] X_SAT = 8'd240;

  logic [7:0]       x;
  logic [1:0]       hflag;
  logic [1:0]       vflag;
  logic [1:0]       h_next;
  logic [1:0]       v_next;
  logic [1:0][15:0] live_h;
  logic [1:0][15:0] live_v;
  logic [1:0][15:0] cmp_h;
  logic             unused_dispcnt;

  assign live_h = {win1h, win0h};
  assign live_v = {win1v, win0v};
  assign unused_dispcnt = ^{dispcnt[15], dispcnt[12:0]};

`ifdef WINDOW_SHADOW_EN
  // Vertical compares only happen at line_start, where a shadow would equal
  // the live value, so only the horizontal registers need shadowing.
  logic [1:0][15:0] shadow_h;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_h <= '0;
    end else if (line_start) begin
      shadow_h <= live_h;
    end
  end

  assign cmp_h = shadow_h;
`else
  assign cmp_h = live_h;
`endif

  always_comb begin
    h_next = '0;
    v_next = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      h_next[n] = (hflag[n] | (x == cmp_h[n][15:8])) & ~(x == cmp_h[n][7:0]);
      v_next[n] = (vcount == 8'd0) ? (live_v[n][15:8] > live_v[n][7:0]) : vflag[n];
      if (vcount == live_v[n][15:8]) v_next[n] = 1'b1;
      if (vcount == live_v[n][7:0])  v_next[n] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x         <= '0;
      hflag     <= '0;
      vflag     <= '0;
      win0      <= 1'b0;
      win1      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (line_start) begin
        x     <= '0;
        hflag <= {live_h[1][15:8] > live_h[1][7:0], live_h[0][15:8] > live_h[0][7:0]};
        vflag <= v_next;
      end else if (pixel_valid) begin
        hflag     <= h_next;
        x         <= (x == X_SAT) ? X_SAT : x + 8'd1;
        win0      <= dispcnt[13] & h_next[0] & vflag[0];
        win1      <= dispcnt[14] & h_next[1] & vflag[1];
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_window_region_gen.sv
// Scoreboard bench for pe_window_region_gen: the driver queues expected flags per pixel,
// a negedge monitor pops and compares them whenever out_valid is high.
module tb_pe_window_region_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  vcount;
  logic        pixel_valid;
  logic [15:0] win0h, win1h, win0v, win1v, dispcnt;
  logic        win0, win1, out_valid;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int ov_count = 0;
  int next_v   = 0;

`ifdef WINDOW_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  typedef struct {
    logic w0;
    logic w1;
    int   cyc;
    int   line;
    int   x;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  pe_window_region_gen dut (
    .clock      (clock),
    .reset      (reset),
    .line_start (line_start),
    .vcount     (vcount),
    .pixel_valid(pixel_valid),
    .win0h      (win0h),
    .win1h      (win1h),
    .win0v      (win0v),
    .win1v      (win1v),
    .dispcnt    (dispcnt),
    .win0       (win0),
    .win1       (win1),
    .out_valid  (out_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Rectangle reference: [a,b) when a<=b, otherwise the wrapped [0,b) + [a,end].
  function automatic bit in_rng(input int v, input int a, input int b);
    if (a <= b) return (v >= a) && (v < b);
    return (v < b) || (v >= a);
  endfunction

  function automatic bit win_model(input logic en, input logic [15:0] h,
                                   input logic [15:0] vr, input int x, input int v);
    return en && in_rng(x, int'(h[15:8]), int'(h[7:0])) && in_rng(v, int'(vr[15:8]), int'(vr[7:0]));
  endfunction

  always @(negedge clock) begin
    if (out_valid) begin
      ov_count++;
      if (sb.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("win0 line=%0d x=%0d", mon_e.line, mon_e.x), int'(win0), int'(mon_e.w0));
        check($sformatf("win1 line=%0d x=%0d", mon_e.line, mon_e.x), int'(win1), int'(mon_e.w1));
        check($sformatf("latency line=%0d x=%0d", mon_e.line, mon_e.x), cyc - mon_e.cyc, 1);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_line_start(input int v);
    line_start = 1'b1;
    vcount     = 8'(v);
    tick();
    line_start = 1'b0;
    next_v     = (v + 1) % 228;
  endtask

  task automatic goto_line(input int v);
    while (next_v != v) do_line_start(next_v);
  endtask

  task automatic pix(input logic e0, input logic e1, input int v, input int x);
    sb.push_back(exp_t'{e0, e1, cyc, v, x});
    pixel_valid = 1'b1;
    tick();
  endtask

  task automatic run_line(input int v, input int n, input bit vzero);
    logic e0, e1;
    goto_line(v);
    do_line_start(v);
    for (int x = 0; x < n; x++) begin
      e0 = win_model(dispcnt[13], win0h, win0v, x, v) && !vzero;
      e1 = win_model(dispcnt[14], win1h, win1v, x, v) && !vzero;
      pix(e0, e1, v, x);
    end
    pixel_valid = 1'b0;
    tick();
  endtask

  int t2_lines[9] = '{0, 5, 15, 16, 17, 100, 127, 128, 159};

  initial begin
    reset = 1'b1; line_start = 1'b0; pixel_valid = 1'b0; vcount = '0;
    win0h = '0; win1h = '0; win0v = '0; win1v = '0; dispcnt = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset win0", int'(win0), 0);
    check("reset win1", int'(win1), 0);
    check("reset out_valid", int'(out_valid), 0);
    reset = 1'b0;
    tick();

    // Plain window 0 over a full frame.
    win0h = 16'h1050; win0v = 16'h2040; dispcnt = 16'h2000;
    for (int v = 0; v < 160; v++) run_line(v, 240, 1'b0);
    goto_line(0);

    // Wrapped window 1, window 0 still active.
    win1h = 16'hC828; win1v = 16'h8010; dispcnt = 16'h6000;
    foreach (t2_lines[i]) run_line(t2_lines[i], 240, 1'b0);

    // Degenerate X1 == X2, then X2 beyond the screen edge.
    dispcnt = 16'h2000; win0h = 16'h3030;
    run_line(32, 240, 1'b0);
    run_line(40, 240, 1'b0);
    win0h = 16'h00F8;
    run_line(31, 240, 1'b0);
    run_line(32, 240, 1'b0);
    run_line(50, 240, 1'b0);
    tick();
    check("hold win0 after last pixel", int'(win0), 1);
    check("out_valid idle", int'(out_valid), 0);
    run_line(63, 240, 1'b0);
    run_line(64, 240, 1'b0);

    // Back-to-back strobes and x saturation.
    win0h = 16'h1050;
    ov_count = 0;
    run_line(40, 240, 1'b0);
    check("out_valid cycles 240", ov_count, 240);
    ov_count = 0;
    run_line(41, 241, 1'b0);
    check("out_valid cycles 241", ov_count, 241);

    // Mid-line register write at x=31.
    goto_line(45);
    do_line_start(45);
    for (int x = 0; x < 240; x++) begin
      if (x == 31) win0h = 16'h0010;
      pix(SHADOW ? in_rng(x, 16, 80) : (x >= 16), 1'b0, 45, x);
    end
    pixel_valid = 1'b0;
    tick();
    run_line(46, 240, 1'b0);

    // Asynchronous reset mid-line at x=50.
    win0h = 16'h1050;
    goto_line(50);
    do_line_start(50);
    for (int x = 0; x <= 50; x++) pix(win_model(dispcnt[13], win0h, win0v, x, 50), 1'b0, 50, x);
    pixel_valid = 1'b0;
    check("win0 before reset", int'(win0), 1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("async reset win0", int'(win0), 0);
    check("async reset win1", int'(win1), 0);
    check("async reset out_valid", int'(out_valid), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    check("scoreboard drained at reset", sb.size(), 0);
    run_line(51, 240, 1'b1);
    run_line(32, 240, 1'b0);

    repeat (3) tick();
    check("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
